uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single transmit port of `uart_top` among N independent requesters. It accepts one byte at a time from the winning requester, issues a one-cycle `i_tx_stb` to the UART, tracks `o_tx_busy` through the whole frame, and aborts with a timeout flag if the UART never acknowledges. It sits between the client logic and `uart_top`. Its `o_tx_data`/`o_tx_stb` drive the UART inputs, and the UART's `o_tx_busy` feeds back into `i_tx_busy`.

---
 rtl/uart_tx_arbiter_if.sv | 14 +
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake plus UART transmit signals shared with the arbiter
interface uart_tx_arbiter_if #(
   parameter int N      = 4,
   parameter int DATA_W = 8
);
   logic [N-1:0]        req_valid;
   logic [N*DATA_W-1:0] req_data;
   logic [N-1:0]        req_ready;
   logic [DATA_W-1:0]   o_tx_data;
   logic                o_tx_stb;
   logic                i_tx_busy;
   modport slave  (input req_valid, req_data, i_tx_busy, output req_ready, o_tx_data, o_tx_stb);
   modport master (output req_valid, req_data, i_tx_busy, input req_ready, o_tx_data, o_tx_stb);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmit port among N requesters
module uart_tx_arbiter #(
   parameter int  N           = 4,
   parameter int  DATA_W      = 8,
   parameter int  ACK_TIMEOUT = 16,
   localparam int GW          = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus,
   output logic [GW-1:0]    o_grant_id,
   output logic             o_active,
   output logic             o_timeout,
   output logic [15:0]      o_tx_count
);
   localparam int          CW  = $clog2(ACK_TIMEOUT);
   localparam logic [GW:0] NV  = (GW+1)'(N);
   localparam logic [GW:0] ONE = (GW+1)'(1);
   typedef enum logic [1:0] {IDLE, STROBE, WAIT_BUSY, WAIT_DONE} state_t;
   state_t            r_state, w_next;
   logic [GW-1:0]     r_last, r_grant, w_win;
   logic [GW:0]       w_sh, w_off, w_sum;
   logic [N-1:0]      w_rot, w_onehot, r_ready;
   logic [DATA_W-1:0] w_wdata, r_data;
   logic [CW-1:0]     r_cnt;
   logic [15:0]       r_tx_count;
   logic              r_stb, r_active, r_timeout, w_grant, w_timeout, w_done;

   assign bus.req_ready = r_ready;
   assign bus.o_tx_data = r_data;
   assign bus.o_tx_stb  = r_stb;
   assign o_grant_id    = r_grant;
   assign o_active      = r_active;
   assign o_timeout     = r_timeout;
   assign o_tx_count    = r_tx_count;

   // rotate requests so bit 0 is the requester just after the last winner, then take the lowest set bit
   always_comb begin
      w_sh     = {1'b0, r_last} + ONE;
      w_rot    = N'({bus.req_valid, bus.req_valid} >> w_sh);
      w_off    = '0;
      for (int k = N - 1; k >= 0; k--) if (w_rot[k]) w_off = (GW+1)'(k);
      w_sum    = w_sh + w_off;
      w_win    = GW'((w_sum >= NV) ? w_sum - NV : w_sum);
      w_onehot = '0;
      w_wdata  = '0;
      for (int k = 0; k < N; k++) begin
         if (w_win == GW'(k)) begin
            w_onehot[k] = 1'b1;
            w_wdata     = bus.req_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // next state plus the grant, timeout and frame-complete events that drive the registered outputs
   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      w_timeout = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         IDLE: if (!bus.i_tx_busy && |bus.req_valid) begin
            w_next  = STROBE;
            w_grant = 1'b1;
         end
         STROBE: w_next = WAIT_BUSY;
         WAIT_BUSY: if (bus.i_tx_busy) w_next = WAIT_DONE;
            else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
               w_next    = IDLE;
               w_timeout = 1'b1;
            end
         default: if (!bus.i_tx_busy) begin
            w_next = IDLE;
            w_done = 1'b1;
         end
      endcase
   end

   // state and all outputs are flops; reset clears them immediately, and last=N-1 makes requester 0 win first
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_last     <= GW'(N - 1);
         r_grant    <= '0;
         r_data     <= '0;
         r_ready    <= '0;
         r_stb      <= 1'b0;
         r_active   <= 1'b0;
         r_timeout  <= 1'b0;
         r_cnt      <= '0;
         r_tx_count <= '0;
      end else begin
         r_state   <= w_next;
         r_stb     <= (w_next == STROBE);
         r_ready   <= w_grant ? w_onehot : '0;
         r_active  <= (w_next != IDLE);
         r_timeout <= w_timeout;
         r_cnt     <= (r_state == WAIT_BUSY) ? r_cnt + CW'(1) : '0;
         if (w_grant) begin
            r_data  <= w_wdata;
            r_grant <= w_win;
            r_last  <= w_win;
         end
         if (w_done) r_tx_count <= r_tx_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic against a round-robin reference model
module tb_uart_tx_arbiter;
   localparam int N = 4, DW = 8, AT = 16;
   logic clk = 1'b0;
   logic rst;
   logic [1:0] gid;
   logic act, tmo;
   logic [15:0] cnt;
   int checks = 0, errors = 0;
   int rem = 0, pend = 0, blen = 1;
   bit auto_busy = 1'b1;
   int m_last, exp_done, exp_tmo, obs_tmo;
   int n, g, t_prev, extra;
   logic [N-1:0] pv;
   logic [N*DW-1:0] pd;

   uart_tx_arbiter_if #(.N(N), .DATA_W(DW)) bus ();

   uart_tx_arbiter #(.N(N), .DATA_W(DW), .ACK_TIMEOUT(AT)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .o_grant_id(gid), .o_active(act), .o_timeout(tmo), .o_tx_count(cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // one clock; afterwards the UART model raises busy the cycle after a strobe for blen cycles (0 = never)
   task automatic step();
      @(posedge clk);
      #1;
      if (rem > 0) rem--;
      if (pend > 0) begin
         rem  = pend;
         pend = 0;
      end
      if (auto_busy) bus.i_tx_busy = (rem > 0);
      if (auto_busy && bus.o_tx_stb === 1'b1) pend = blen;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (act !== 1'b0 && k < 200) begin
         step();
         k++;
      end
      chk({tag, "_idle"}, 32'(act), 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.req_valid = '0;
      rem = 0;
      pend = 0;
      bus.i_tx_busy = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   // reference: winner is the first valid requester after the previous winner, in circular order
   task automatic rnd_cycle(input bit gen);
      int w;
      logic [N-1:0] sh;
      logic [N*DW-1:0] dsh;
      pv = bus.req_valid;
      pd = bus.req_data;
      blen = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
      step();
      if (tmo === 1'b1) obs_tmo++;
      if (bus.o_tx_stb === 1'b1) begin
         w = -1;
         for (int k = 1; k <= N; k++) begin
            sh = pv >> ((m_last + k) % N);
            if (w < 0 && sh[0]) w = (m_last + k) % N;
         end
         chk("rnd_gid", 32'(gid), w);
         if (w < 0) w = 0;
         dsh = pd >> (w * DW);
         chk("rnd_ready", 32'(bus.req_ready), 1 << w);
         chk("rnd_data", 32'(bus.o_tx_data), 32'(dsh[DW-1:0]));
         m_last = w;
         if (blen == 0) exp_tmo++;
         else exp_done++;
      end else chk("rnd_noready", 32'(bus.req_ready), 0);
      for (int i = 0; i < N; i++) begin
         if (bus.req_ready[i] === 1'b1 || !bus.req_valid[i]) begin
            bus.req_valid[i] = gen && ($urandom_range(0, 2) == 0);
            if (bus.req_valid[i]) bus.req_data[i*DW +: DW] = 8'($urandom);
         end else if (gen && $urandom_range(0, 31) == 0) bus.req_valid[i] = 1'b0;
      end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_data = '0;
      bus.i_tx_busy = 1'b0;
      rst = 1'b1;
      #1 rst = 1'b0;
      step();
      step();
      chk("rst_stb", 32'(bus.o_tx_stb), 0);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_tmo", 32'(tmo), 0);
      chk("rst_act", 32'(act), 0);
      chk("rst_data", 32'(bus.o_tx_data), 0);
      chk("rst_gid", 32'(gid), 0);
      chk("rst_cnt", 32'(cnt), 0);
      rst = 1'b1;
      // single request, busy lasting 10 cycles
      bus.req_data = 32'h00A5_0000;
      bus.req_valid = 4'b0100;
      blen = 10;
      step();
      chk("s1_stb", 32'(bus.o_tx_stb), 1);
      chk("s1_ready", 32'(bus.req_ready), 32'b0100);
      chk("s1_data", 32'(bus.o_tx_data), 32'hA5);
      chk("s1_gid", 32'(gid), 2);
      chk("s1_act", 32'(act), 1);
      bus.req_valid = '0;
      n = 0;
      extra = 0;
      while (act === 1'b1 && n < 50) begin
         step();
         n++;
         if (bus.o_tx_stb === 1'b1) extra++;
      end
      chk("s1_len", n, 12);
      chk("s1_extra", extra, 0);
      chk("s1_cnt", 32'(cnt), 1);
      // round-robin with all requesters held, one-cycle busy
      do_reset();
      blen = 1;
      bus.req_data = 32'h1312_1110;
      bus.req_valid = 4'hF;
      g = 0;
      n = 0;
      t_prev = 0;
      while (g < 8 && n < 200) begin
         step();
         n++;
         if (bus.o_tx_stb === 1'b1) begin
            chk("rr_data", 32'(bus.o_tx_data), 32'h10 + (g % 4));
            chk("rr_ready", 32'(bus.req_ready), 1 << (g % 4));
            chk("rr_gid", 32'(gid), g % 4);
            if (g > 0) chk("rr_gap", n - t_prev, 4);
            t_prev = n;
            g++;
         end else chk("rr_noready", 32'(bus.req_ready), 0);
      end
      chk("rr_grants", g, 8);
      bus.req_valid = '0;
      wait_idle("rr");
      // busy already high in IDLE holds off the grant
      auto_busy = 1'b0;
      bus.i_tx_busy = 1'b1;
      bus.req_data = 32'h0000_0077;
      bus.req_valid = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("bg_hold", 32'(bus.o_tx_stb), 0);
      end
      bus.i_tx_busy = 1'b0;
      auto_busy = 1'b1;
      blen = 3;
      step();
      chk("bg_stb", 32'(bus.o_tx_stb), 1);
      chk("bg_data", 32'(bus.o_tx_data), 32'h77);
      bus.req_valid = '0;
      wait_idle("bg");
      // acknowledge timeout
      do_reset();
      blen = 0;
      bus.req_data = 32'h0000_5A00;
      bus.req_valid = 4'b0010;
      step();
      chk("to_stb", 32'(bus.o_tx_stb), 1);
      chk("to_gid", 32'(gid), 1);
      bus.req_valid = '0;
      for (int j = 1; j <= AT + 1; j++) begin
         step();
         chk("to_pulse", 32'(tmo), 32'(j == AT + 1));
         chk("to_act", 32'(act), 32'(j != AT + 1));
      end
      step();
      chk("to_once", 32'(tmo), 0);
      chk("to_cnt", 32'(cnt), 0);
      // asynchronous reset in WAIT_DONE
      bus.req_data = 32'hC300_0000;
      bus.req_valid = 4'b1000;
      blen = 20;
      step();
      chk("mf_gid_pre", 32'(gid), 3);
      bus.req_valid = '0;
      step();
      step();
      step();
      chk("mf_act_pre", 32'(act), 1);
      #2 rst = 1'b0;
      #1;
      chk("mf_stb", 32'(bus.o_tx_stb), 0);
      chk("mf_ready", 32'(bus.req_ready), 0);
      chk("mf_tmo", 32'(tmo), 0);
      chk("mf_act", 32'(act), 0);
      chk("mf_data", 32'(bus.o_tx_data), 0);
      chk("mf_gid", 32'(gid), 0);
      chk("mf_cnt", 32'(cnt), 0);
      rem = 0;
      pend = 0;
      bus.i_tx_busy = 1'b0;
      bus.req_data = 32'h3300_0011;
      bus.req_valid = 4'b1001;
      blen = 2;
      step();
      rst = 1'b1;
      step();
      chk("mf_first_stb", 32'(bus.o_tx_stb), 1);
      chk("mf_first_gid", 32'(gid), 0);
      chk("mf_first_ready", 32'(bus.req_ready), 32'b0001);
      chk("mf_first_data", 32'(bus.o_tx_data), 32'h11);
      bus.req_valid = 4'b1000;
      wait_idle("mf1");
      step();
      chk("mf_next_gid", 32'(gid), 3);
      chk("mf_next_data", 32'(bus.o_tx_data), 32'h33);
      bus.req_valid = '0;
      wait_idle("mf2");
      // frame counter wrap from a preloaded 0xFFFF
      force dut.r_tx_count = 16'hFFFF;
      #1 release dut.r_tx_count;
      bus.req_data = 32'h00E7_0000;
      bus.req_valid = 4'b0100;
      blen = 2;
      step();
      chk("wr_stb", 32'(bus.o_tx_stb), 1);
      bus.req_valid = '0;
      wait_idle("wr");
      chk("wr_cnt", 32'(cnt), 0);
      // randomized traffic against the reference model
      do_reset();
      m_last = N - 1;
      exp_done = 0;
      exp_tmo = 0;
      obs_tmo = 0;
      for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
      n = 0;
      while ((bus.req_valid !== '0 || act !== 1'b0) && n < 1000) begin
         rnd_cycle(1'b0);
         n++;
      end
      chk("rnd_drain", 32'(act), 0);
      chk("rnd_cnt", 32'(cnt), exp_done & 32'hFFFF);
      chk("rnd_tmo", obs_tmo, exp_tmo);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
